// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB2AHB bridge controllers: state encoding,
// packet/response field offsets and counter sizing.
package bridge_pkg;

  typedef enum logic [1:0] {
    StWake  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StSleep = 2'd3
  } state_e;

  // Request packet layout: {rd0_wr1, valid, addr, wr_data}
  function automatic int unsigned pkt_rdwr_bit(int unsigned aw, int unsigned dw);
    return aw + dw + 1;
  endfunction

  function automatic int unsigned pkt_valid_bit(int unsigned aw, int unsigned dw);
    return aw + dw;
  endfunction

  function automatic int unsigned pkt_addr_lsb(int unsigned dw);
    return dw;
  endfunction

  // Response packet layout: {err, data}
  function automatic int unsigned rsp_err_bit(int unsigned dw);
    return dw;
  endfunction

  // Bits needed to hold values 0..max
  function automatic int unsigned cnt_width(int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/bridge_outstanding_ctr.sv
// Saturating up/down counter of transactions in flight, with clear and an
// underflow flag raised when a decrement is requested at zero.
module bridge_outstanding_ctr #(
  parameter int unsigned MaxCount = 4,
  parameter int unsigned Width    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o,
  output logic             underflow_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign underflow_o = dec_i && (cnt_q == '0);
  assign cnt_o       = cnt_q;

  // An underflowing decrement is ignored, so a same-cycle increment still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (!dec_i || underflow_o)) begin
      if (cnt_q != Width'(MaxCount)) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && !underflow_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bridge_src_ctrl.sv
// Source-domain bridge controller: pushes slave requests into the request FIFO,
// returns in-order read responses and sequences wake / drain / sleep.
module bridge_src_ctrl
  import bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DRAIN_TIMEOUT   = 256,
  parameter int unsigned WAKE_CYCLES     = 2,
  localparam int unsigned PKT_WIDTH      = ADDR_WIDTH + DATA_WIDTH + 2
) (
  input  logic                  i_clk_src,
  input  logic                  i_rstn_src,
  input  logic                  i_src_sleep_req,
  input  logic                  i_sink_sleep_status,
  input  logic                  i_valid,
  input  logic                  i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_rd_err,
  input  logic                  i_req_fifo_full,
  input  logic                  i_req_fifo_empty,
  output logic                  o_req_fifo_wr_en,
  output logic [PKT_WIDTH-1:0]  o_packet,
  input  logic                  i_rsp_fifo_empty,
  input  logic [DATA_WIDTH:0]   i_rsp_packet,
  output logic                  o_rsp_fifo_rd_en,
  output logic [3:0]            o_outstanding,
  output logic                  o_src_sleep_ack,
  output logic                  o_source_sleep_status,
  output logic                  o_sink_rstn,
  output logic                  o_drain_timeout,
  output logic                  o_proto_err
);

  localparam int unsigned CntW     = cnt_width(MAX_OUTSTANDING);
  localparam int unsigned WakeW    = cnt_width(WAKE_CYCLES);
  localparam int unsigned DrainW   = cnt_width(DRAIN_TIMEOUT);
  localparam int unsigned RdwrBit  = pkt_rdwr_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned ValidBit = pkt_valid_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned AddrLsb  = pkt_addr_lsb(DATA_WIDTH);
  localparam int unsigned ErrBit   = rsp_err_bit(DATA_WIDTH);

  state_e              state_q, state_d;
  logic [WakeW-1:0]    wake_cnt_q, wake_cnt_d;
  logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CntW-1:0]     out_cnt;
  logic                sleep_cond, rd_accept, pop, underflow, drain_tmo, rsp_take;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                rd_err_q, rd_err_d, rd_valid_q, rd_valid_d;
  logic                proto_q, proto_d, tmo_q, tmo_d, ack_q, ack_d, sink_rstn_q, sink_rstn_d;

  assign sleep_cond = i_src_sleep_req | i_sink_sleep_status;

  assign o_ready = (state_q == StRun) && !i_req_fifo_full && !sleep_cond &&
                   ((out_cnt < CntW'(MAX_OUTSTANDING)) || i_rd0_wr1);
  assign o_req_fifo_wr_en = i_valid && o_ready;
  assign rd_accept        = o_req_fifo_wr_en && !i_rd0_wr1;

  always_comb begin
    o_packet                          = '0;
    o_packet[RdwrBit]                 = i_rd0_wr1;
    o_packet[ValidBit]                = 1'b1;
    o_packet[AddrLsb +: ADDR_WIDTH]   = i_addr;
    o_packet[DATA_WIDTH-1:0]          = i_wr_data;
  end

  assign pop              = ((state_q == StRun) || (state_q == StDrain)) && !i_rsp_fifo_empty;
  assign o_rsp_fifo_rd_en = pop;
  // A response with nothing outstanding is a protocol violation and is dropped.
  assign rsp_take         = pop && !underflow;

  bridge_outstanding_ctr #(
    .MaxCount (MAX_OUTSTANDING),
    .Width    (CntW)
  ) u_out_ctr (
    .clk_i       (i_clk_src),
    .rst_ni      (i_rstn_src),
    .inc_i       (rd_accept),
    .dec_i       (pop),
    .clr_i       (drain_tmo),
    .cnt_o       (out_cnt),
    .underflow_o (underflow)
  );

  assign o_outstanding = 4'(out_cnt);

  always_comb begin
    state_d     = state_q;
    wake_cnt_d  = '0;
    drain_cnt_d = '0;
    drain_tmo   = 1'b0;
    unique case (state_q)
      StWake: begin
        wake_cnt_d = wake_cnt_q + 1'b1;
        if (wake_cnt_q == WakeW'(WAKE_CYCLES - 1)) state_d = sleep_cond ? StSleep : StRun;
      end
      StRun: begin
        if (sleep_cond) state_d = StDrain;
      end
      StDrain: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if ((out_cnt == '0) && i_req_fifo_empty && i_rsp_fifo_empty) begin
          state_d = StSleep;
        end else if ((DRAIN_TIMEOUT != 0) && (drain_cnt_q == DrainW'(DRAIN_TIMEOUT - 1))) begin
          drain_tmo = 1'b1;
          state_d   = StSleep;
        end
      end
      StSleep: begin
        if (!sleep_cond) state_d = StWake;
      end
      default: state_d = StWake;
    endcase
  end

  always_comb begin
    rd_data_d   = rsp_take ? i_rsp_packet[DATA_WIDTH-1:0] : rd_data_q;
    rd_err_d    = rsp_take ? i_rsp_packet[ErrBit] : rd_err_q;
    rd_valid_d  = rsp_take;
    proto_d     = proto_q | (pop && underflow);
    tmo_d       = tmo_q | drain_tmo;
    // Ack and sink reset follow the state being entered so they change with it.
    ack_d       = (state_d == StSleep) && i_src_sleep_req;
    sink_rstn_d = (state_d == StSleep) ? !i_sink_sleep_status : 1'b1;
  end

  always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
    if (!i_rstn_src) begin
      state_q     <= StWake;
      wake_cnt_q  <= '0;
      drain_cnt_q <= '0;
      rd_data_q   <= '0;
      rd_err_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      proto_q     <= 1'b0;
      tmo_q       <= 1'b0;
      ack_q       <= 1'b0;
      sink_rstn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_cnt_q  <= wake_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_err_q    <= rd_err_d;
      rd_valid_q  <= rd_valid_d;
      proto_q     <= proto_d;
      tmo_q       <= tmo_d;
      ack_q       <= ack_d;
      sink_rstn_q <= sink_rstn_d;
    end
  end

  assign o_rd_data             = rd_data_q;
  assign o_rd_err              = rd_err_q;
  assign o_rd_valid            = rd_valid_q;
  assign o_proto_err           = proto_q;
  assign o_drain_timeout       = tmo_q;
  assign o_src_sleep_ack       = ack_q;
  assign o_sink_rstn           = sink_rstn_q;
  assign o_source_sleep_status = (state_q == StSleep);

endmodule

// File: tb/tb_bridge_src_ctrl.sv
// Bench for bridge_src_ctrl: directed scenarios then random traffic, all checked
// cycle by cycle against a queue-based behavioural model.
module tb_bridge_src_ctrl;

  localparam int unsigned AW = 32, DW = 32, MAXO = 4, DT = 8, WC = 2;
  localparam int unsigned PW = AW + DW + 2;
  localparam int MWake = 0, MRun = 1, MDrain = 2, MSleep = 3;

  logic          clk = 1'b0, rstn = 1'b0;
  logic          src_req = 0, sink_sleep = 0, valid = 0, rd0_wr1 = 0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          req_full = 0, req_empty = 1, rsp_empty = 1;
  logic [DW:0]   rsp_packet = '0;
  logic          o_ready, o_rd_valid, o_rd_err, o_req_fifo_wr_en, o_rsp_fifo_rd_en;
  logic [DW-1:0] o_rd_data;
  logic [PW-1:0] o_packet;
  logic [3:0]    o_outstanding;
  logic          o_src_sleep_ack, o_source_sleep_status, o_sink_rstn;
  logic          o_drain_timeout, o_proto_err;

  int checks = 0, errors = 0;

  // Behavioural model
  int            mode, wake_el, drain_el;
  logic [AW-1:0] rd_q[$];
  logic          e_valid, e_err, e_proto, e_tmo, e_ack, e_sink;
  logic [DW-1:0] e_data;

  always #5 clk = ~clk;

  bridge_src_ctrl #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO),
    .DRAIN_TIMEOUT   (DT),
    .WAKE_CYCLES     (WC)
  ) dut (
    .i_clk_src             (clk),
    .i_rstn_src            (rstn),
    .i_src_sleep_req       (src_req),
    .i_sink_sleep_status   (sink_sleep),
    .i_valid               (valid),
    .i_rd0_wr1             (rd0_wr1),
    .i_addr                (addr),
    .i_wr_data             (wr_data),
    .o_ready               (o_ready),
    .o_rd_data             (o_rd_data),
    .o_rd_valid            (o_rd_valid),
    .o_rd_err              (o_rd_err),
    .i_req_fifo_full       (req_full),
    .i_req_fifo_empty      (req_empty),
    .o_req_fifo_wr_en      (o_req_fifo_wr_en),
    .o_packet              (o_packet),
    .i_rsp_fifo_empty      (rsp_empty),
    .i_rsp_packet          (rsp_packet),
    .o_rsp_fifo_rd_en      (o_rsp_fifo_rd_en),
    .o_outstanding         (o_outstanding),
    .o_src_sleep_ack       (o_src_sleep_ack),
    .o_source_sleep_status (o_source_sleep_status),
    .o_sink_rstn           (o_sink_rstn),
    .o_drain_timeout       (o_drain_timeout),
    .o_proto_err           (o_proto_err)
  );

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    check("rd_valid", o_rd_valid, e_valid);
    check("rd_data", o_rd_data, e_data);
    check("rd_err", o_rd_err, e_err);
    check("proto_err", o_proto_err, e_proto);
    check("drain_timeout", o_drain_timeout, e_tmo);
    check("sleep_ack", o_src_sleep_ack, e_ack);
    check("sink_rstn", o_sink_rstn, e_sink);
    check("sleep_status", o_source_sleep_status, mode == MSleep);
    check("outstanding", o_outstanding, 4'(rd_q.size()));
  endtask

  task automatic model_reset();
    mode = MWake; wake_el = 0; drain_el = 0; rd_q.delete();
    e_valid = 0; e_err = 0; e_proto = 0; e_tmo = 0; e_ack = 0; e_sink = 0; e_data = '0;
  endtask

  // One clock: check same-cycle outputs, advance the model, check registered outputs.
  task automatic tick();
    logic sc, rdy, wen, ren;
    int   n;
    #2;
    sc  = src_req | sink_sleep;
    rdy = (mode == MRun) && !req_full && (rd_q.size() < MAXO || rd0_wr1) && !sc;
    wen = valid && rdy;
    ren = (mode == MRun || mode == MDrain) && !rsp_empty;
    check("ready", o_ready, rdy);
    check("req_wr_en", o_req_fifo_wr_en, wen);
    check("packet", o_packet, {rd0_wr1, 1'b1, addr, wr_data});
    check("rsp_rd_en", o_rsp_fifo_rd_en, ren);
    n = rd_q.size();
    e_valid = 0;
    if (ren) begin
      if (n > 0) begin
        e_valid = 1; e_data = rsp_packet[DW-1:0]; e_err = rsp_packet[DW];
        void'(rd_q.pop_front());
      end else begin
        e_proto = 1;
      end
    end
    if (wen && !rd0_wr1) rd_q.push_back(addr);
    case (mode)
      MWake: begin
        wake_el++;
        if (wake_el == WC) mode = sc ? MSleep : MRun;
      end
      MRun: if (sc) begin mode = MDrain; drain_el = 0; end
      MDrain: begin
        drain_el++;
        if (n == 0 && req_empty && rsp_empty) mode = MSleep;
        else if (drain_el == DT) begin mode = MSleep; e_tmo = 1; rd_q.delete(); end
      end
      default: if (!sc) begin mode = MWake; wake_el = 0; end
    endcase
    e_ack  = (mode == MSleep) && src_req;
    e_sink = (mode == MSleep) ? !sink_sleep : 1'b1;
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    check_regs();
    check("reset_ready", o_ready, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    bit done;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Wake sequence
    tick();
    check("sink_rstn_wake", o_sink_rstn, 1'b1);
    check("ready_in_wake", o_ready, 1'b0);
    tick();
    check("ready_after_wake", o_ready, 1'b1);

    // Five reads, only four fit
    for (int i = 0; i < 5; i++) begin
      valid = 1; rd0_wr1 = 0; addr = 32'h100 + 32'(4 * i);
      if (i == 4) begin
        #1;
        check("ready_full_out", o_ready, 1'b0);
        check("outstanding_max", o_outstanding, 4'd4);
      end
      tick();
    end
    rsp_empty = 0; rsp_packet = {1'b0, 32'hDEAD};
    tick();
    rsp_empty = 1;
    check("rsp_valid", o_rd_valid, 1'b1);
    check("rsp_data", o_rd_data, 32'hDEAD);
    check("outstanding_3", o_outstanding, 4'd3);
    tick();
    check("fifth_accepted", o_outstanding, 4'd4);
    valid = 0;
    for (int i = 0; i < 4; i++) begin
      rsp_empty = 0; rsp_packet = {1'($urandom_range(0, 1)), 32'($urandom)};
      tick();
    end
    rsp_empty = 1;

    // Write blocked by full FIFO
    valid = 1; rd0_wr1 = 1; addr = 32'hA0; wr_data = 32'h1234; req_full = 1;
    for (int i = 0; i < 3; i++) begin
      #1; check("wr_blocked", o_req_fifo_wr_en, 1'b0);
      tick();
    end
    req_full = 0;
    #1;
    check("wr_push", o_req_fifo_wr_en, 1'b1);
    check("wr_packet", o_packet, {2'b11, 32'hA0, 32'h1234});
    tick();

    // Drain with two reads outstanding
    rd0_wr1 = 0; addr = 32'h200;
    tick(); tick();
    valid = 0; src_req = 1;
    tick();
    #1; check("drain_ready", o_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      rsp_empty = 0; rsp_packet = {1'(i), 32'hC0 + 32'(i)};
      tick();
    end
    rsp_empty = 1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = o_source_sleep_status;
    end
    check("drain_sleep", o_source_sleep_status, 1'b1);
    check("drain_ack", o_src_sleep_ack, 1'b1);
    check("drain_no_tmo", o_drain_timeout, 1'b0);
    src_req = 0;
    tick();
    check("ack_clear", o_src_sleep_ack, 1'b0);
    tick(); tick();
    check("rerun_ready", o_ready, 1'b1);

    // Drain timeout with an unanswered read
    valid = 1; rd0_wr1 = 0; addr = 32'h300;
    tick();
    valid = 0; src_req = 1;
    for (int i = 0; i < 8; i++) tick();
    check("tmo_not_yet", o_source_sleep_status, 1'b0);
    tick();
    check("tmo_sleep", o_source_sleep_status, 1'b1);
    check("tmo_flag", o_drain_timeout, 1'b1);
    check("tmo_cleared", o_outstanding, 4'd0);
    src_req = 0;
    tick(); tick(); tick();

    // Protocol error and simultaneous accept/pop
    rsp_empty = 0; rsp_packet = {1'b0, 32'hBAD};
    tick();
    rsp_empty = 1;
    check("proto_no_valid", o_rd_valid, 1'b0);
    check("proto_flag", o_proto_err, 1'b1);
    valid = 1; addr = 32'h400;
    tick();
    rsp_empty = 0; rsp_packet = {1'b1, 32'h55};
    tick();
    check("acc_pop_count", o_outstanding, 4'd1);
    check("acc_pop_err", o_rd_err, 1'b1);
    valid = 0;
    tick();
    rsp_empty = 1;

    // Random traffic with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        src_req = 0; sink_sleep = 0;
        do_reset();
      end
      valid      = 1'($urandom_range(0, 1));
      rd0_wr1    = ($urandom_range(0, 3) == 0);
      addr       = 32'($urandom);
      wr_data    = 32'($urandom);
      req_full   = ($urandom_range(0, 4) == 0);
      req_empty  = 1'($urandom_range(0, 1));
      rsp_empty  = ($urandom_range(0, 2) != 0);
      rsp_packet = {1'($urandom_range(0, 1)), 32'($urandom)};
      if ($urandom_range(0, 99) < 4) src_req = ~src_req;
      if ($urandom_range(0, 99) < 2) sink_sleep = ~sink_sleep;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
